ahb_timer: RTL and testbench

AHB_TIMER -- requirements
Module: ahb_timer

---
 rtl/ahb_sys_pkg.sv | 45 ++++
 rtl/ahb_timer_prescaler.sv | 28 ++
 rtl/ahb_timer.sv | 182 ++++++++++++++++++
 tb/tb_ahb_timer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sys_pkg.sv
// Shared AHB system definitions: timer register word offsets, CTRL/STATUS bit
// indices, HTRANS/HSIZE encodings and the captured data-phase record.
// Latency: n/a (package). Backpressure: n/a.
package ahb_sys_pkg;

  // Word offsets (HADDR[4:2]) of the timer register map
  localparam logic [2:0] ADDR_LOAD     = 3'd0;  // 0x00
  localparam logic [2:0] ADDR_VALUE    = 3'd1;  // 0x04
  localparam logic [2:0] ADDR_CTRL     = 3'd2;  // 0x08
  localparam logic [2:0] ADDR_STATUS   = 3'd3;  // 0x0C
  localparam logic [2:0] ADDR_PRESCALE = 3'd4;  // 0x10

  // CTRL / STATUS bit positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_PERIODIC = 2;
  localparam int STATUS_IRQ    = 0;

  // AHB transfer encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  // Address-phase information carried into the data phase
  typedef struct packed {
    logic       vld;
    logic       write;
    logic       size_ok;
    logic [2:0] addr;
  } dphase_t;

  // NONSEQ and SEQ carry data; IDLE and BUSY do not
  function automatic logic htrans_active(input logic [1:0] trans);
    logic act;
    case (trans)
      HTRANS_IDLE, HTRANS_BUSY: act = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
      default: act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/ahb_timer_prescaler.sv
// Prescaler for the AHB timer: pulses tick once every prescale+1 enabled cycles.
// Latency: tick is combinational from the registered count. Backpressure: none.
// Ports: HCLK/HRESET clock and sync reset; en gates counting (count held at 0
// while low); clr restarts the count; prescale is the divide-minus-one value.
module ahb_timer_prescaler (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] prescale,
  output logic       tick
);

  logic [7:0] cnt_q;

  assign tick = en & (cnt_q == prescale);

  always_ff @(posedge HCLK) begin
    if (HRESET || clr || !en) begin
      cnt_q <= 8'd0;
    end else if (tick) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/ahb_timer.sv
// AHB-Lite down-counting timer with one-shot/periodic modes and level interrupt.
// Latency: register writes land at the end of the data phase; reads are
// combinational in the data phase. Backpressure: none, HREADYOUT is always 1.
// Ports: HCLK, HRESET (sync, active-high), AHB slave inputs HSEL/HADDR/HTRANS/
// HWRITE/HSIZE/HWDATA/HREADY, outputs HRDATA/HREADYOUT/HRESP, and TIMERINT.
// Optional prescaler at 0x10 is built when AHB_TIMER_PRESCALE_EN is defined.
module ahb_timer
  import ahb_sys_pkg::*;
#(
  parameter logic [31:0] LOAD_RST = 32'hFFFF_FFFF
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        TIMERINT
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  dphase_t     dp_q;
  logic [31:0] load_q;
  logic [31:0] value_q;
  logic [31:0] value_d;
  logic [0:0]  state_q;
  logic [0:0]  state_d;
  logic        irq_en_q;
  logic        periodic_q;
  logic        irq_flag_q;

  logic        en;
  logic        tick;
  logic        wr_vld;
  logic        load_wr;
  logic        ctrl_wr;
  logic        status_wr;
  logic        cnt_act;
  logic        expire;
  logic        irq_set;
  logic [31:0] rdata;
  logic [31:0] prescale_rd;

  // Only HADDR[4:2] selects a register
  logic unused_haddr;
  assign unused_haddr = ^{HADDR[31:5], HADDR[1:0]};

  assign en        = (state_q == ST_RUN);
  assign wr_vld    = dp_q.vld & dp_q.write & dp_q.size_ok;
  assign load_wr   = wr_vld & (dp_q.addr == ADDR_LOAD);
  assign ctrl_wr   = wr_vld & (dp_q.addr == ADDR_CTRL);
  assign status_wr = wr_vld & (dp_q.addr == ADDR_STATUS);

`ifdef AHB_TIMER_PRESCALE_EN
  logic [7:0] prescale_q;
  logic       prescale_wr;

  assign prescale_wr = wr_vld & (dp_q.addr == ADDR_PRESCALE);
  assign prescale_rd = {24'd0, prescale_q};

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      prescale_q <= 8'd0;
    end else if (prescale_wr) begin
      prescale_q <= HWDATA[7:0];
    end
  end

  ahb_timer_prescaler u_prescaler (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .en       (en),
    .clr      (prescale_wr),
    .prescale (prescale_q),
    .tick     (tick)
  );
`else
  assign tick        = en;
  assign prescale_rd = 32'd0;
`endif

  // A LOAD write overrides whatever the counter would do on this tick
  // (decrement, reload, expiry and the interrupt that would come with it).
  assign cnt_act = tick & ~load_wr;
  assign expire  = cnt_act & (value_q == 32'd0) & ~periodic_q;
  // LOAD=0 in periodic mode sits at 0 and interrupts on every tick
  assign irq_set = cnt_act & ((value_q == 32'd1) |
                              ((value_q == 32'd0) & periodic_q & (load_q == 32'd0)));

  always_comb begin
    value_d = value_q;
    if (load_wr) begin
      value_d = HWDATA;
    end else if (cnt_act) begin
      if (value_q == 32'd0) begin
        value_d = periodic_q ? load_q : 32'd0;
      end else begin
        value_d = value_q - 32'd1;
      end
    end
  end

  // Software writing CTRL wins over a one-shot expiry in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_wr && HWDATA[CTRL_EN]) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ctrl_wr) begin
          if (!HWDATA[CTRL_EN]) state_d = ST_IDLE;
        end else if (expire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_q       <= '0;
      load_q     <= LOAD_RST;
      value_q    <= LOAD_RST;
      state_q    <= ST_IDLE;
      irq_en_q   <= 1'b0;
      periodic_q <= 1'b0;
      irq_flag_q <= 1'b0;
    end else begin
      if (HREADY) begin
        dp_q.vld     <= HSEL & htrans_active(HTRANS);
        dp_q.write   <= HWRITE;
        dp_q.size_ok <= (HSIZE == HSIZE_WORD);
        dp_q.addr    <= HADDR[4:2];
      end
      if (load_wr) load_q <= HWDATA;
      value_q <= value_d;
      state_q <= state_d;
      if (ctrl_wr) begin
        irq_en_q   <= HWDATA[CTRL_IRQ_EN];
        periodic_q <= HWDATA[CTRL_PERIODIC];
      end
      if (irq_set) begin
        irq_flag_q <= 1'b1;
      end else if (status_wr && HWDATA[STATUS_IRQ]) begin
        irq_flag_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (dp_q.addr)
      ADDR_LOAD:     rdata = load_q;
      ADDR_VALUE:    rdata = value_q;
      ADDR_CTRL: begin
        rdata[CTRL_EN]       = en;
        rdata[CTRL_IRQ_EN]   = irq_en_q;
        rdata[CTRL_PERIODIC] = periodic_q;
      end
      ADDR_STATUS:   rdata[STATUS_IRQ] = irq_flag_q;
      ADDR_PRESCALE: rdata = prescale_rd;
      default:       rdata = 32'd0;
    endcase
  end

  // Outputs are forced quiet while reset is held, even before the first edge
  assign HRDATA    = (dp_q.vld && !dp_q.write && !HRESET) ? rdata : 32'd0;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign TIMERINT  = irq_flag_q & irq_en_q & ~HRESET;

endmodule

// File: tb/tb_ahb_timer.sv
// Self-checking bench for ahb_timer: directed scenarios plus randomized
// back-to-back traffic checked against a register-level reference model.
module tb_ahb_timer;

  localparam logic [31:0] LOAD_RST = 32'hFFFF_FFFF;
  localparam logic [1:0]  T_IDLE   = 2'b00;
  localparam logic [1:0]  T_NSEQ   = 2'b10;
  localparam logic [2:0]  SZ_WORD  = 3'b010;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = 32'd0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'b010;
  logic [31:0] HWDATA = 32'd0;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        TIMERINT;

  int nvec = 0;
  int nerr = 0;

  always #5 HCLK = ~HCLK;

  ahb_timer #(.LOAD_RST(LOAD_RST)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .TIMERINT(TIMERINT)
  );

  // ---------------- reference model (register level) ----------------
  logic [31:0] m_load, m_value;
  bit          m_en, m_irqen, m_per, m_flag;
  logic [7:0]  m_psc, m_pcnt;
  bit          p_vld, p_wr, p_word;
  logic [2:0]  p_idx;

  always @(posedge HCLK) begin : model
    logic [31:0] d;
    bit wr, lw, cw, sw, pw, tk, acts, irqset, expire;
    if (HRESET) begin
      m_load = LOAD_RST; m_value = LOAD_RST;
      m_en = 0; m_irqen = 0; m_per = 0; m_flag = 0;
      m_psc = 8'd0; m_pcnt = 8'd0; p_vld = 0;
    end else begin
      d  = HWDATA;
      wr = p_vld && p_wr && p_word;
      lw = wr && (p_idx == 3'd0);
      cw = wr && (p_idx == 3'd2);
      sw = wr && (p_idx == 3'd3);
      pw = wr && (p_idx == 3'd4);
`ifdef AHB_TIMER_PRESCALE_EN
      tk = m_en && (m_pcnt == m_psc);
      if (pw || !m_en || tk) m_pcnt = 8'd0; else m_pcnt = m_pcnt + 8'd1;
      if (pw) m_psc = d[7:0];
`else
      tk = m_en;
      if (pw) m_psc = 8'd0;
`endif
      acts   = tk && !lw;
      irqset = acts && (m_value == 1 || (m_value == 0 && m_per && m_load == 0));
      expire = acts && m_value == 0 && !m_per;
      if (lw) m_value = d;
      else if (acts) m_value = (m_value == 0) ? (m_per ? m_load : 32'd0) : m_value - 1;
      if (lw) m_load = d;
      if (cw) begin m_en = d[0]; m_irqen = d[1]; m_per = d[2]; end
      else if (expire) m_en = 0;
      if (irqset) m_flag = 1; else if (sw && d[0]) m_flag = 0;
      p_vld  = HSEL && HTRANS[1];
      p_wr   = HWRITE;
      p_word = (HSIZE == 3'b010);
      p_idx  = HADDR[4:2];
    end
  end

  function automatic logic [31:0] mread(input logic [2:0] idx);
    case (idx)
      3'd0: return m_load;
      3'd1: return m_value;
      3'd2: return {29'd0, m_per, m_irqen, m_en};
      3'd3: return {31'd0, m_flag};
`ifdef AHB_TIMER_PRESCALE_EN
      3'd4: return {24'd0, m_psc};
`endif
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- bus driver ----------------
  bit         last_rd;
  logic [2:0] last_idx;

  // Drives one address phase, crosses the edge, then presents the data phase.
  task automatic bus_cycle(input bit sel, input logic [1:0] trans, input bit wr,
                           input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wdata);
    bit rst;
    HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr; HSIZE = size;
    rst = HRESET;
    @(posedge HCLK); #1;
    last_rd  = sel && trans[1] && !wr && !rst;
    last_idx = addr[4:2];
    HWDATA   = (sel && trans[1] && wr) ? wdata : $urandom;
  endtask

  task automatic wr_reg(input logic [31:0] addr, input logic [31:0] data);
    bus_cycle(1'b1, T_NSEQ, 1'b1, addr, SZ_WORD, data);
  endtask

  task automatic rd_reg(input logic [31:0] addr);
    bus_cycle(1'b1, T_NSEQ, 1'b0, addr, SZ_WORD, 32'd0);
  endtask

  task automatic idle();
    bus_cycle(1'b0, T_IDLE, 1'b0, 32'd0, SZ_WORD, 32'd0);
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    idle(); idle();
    HRESET = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    HRESET = 1'b1;
    bus_cycle(1'b1, T_NSEQ, 1'b0, 32'h4, SZ_WORD, 32'd0);
    bus_cycle(1'b1, T_NSEQ, 1'b0, 32'h0, SZ_WORD, 32'd0);
    nvec++; if (HRDATA !== 32'd0) begin nerr++; $display("FAIL rst_hrdata: got %h want 0", HRDATA); end
    nvec++; if ({HREADYOUT, HRESP} !== 2'b10) begin nerr++; $display("FAIL rst_resp: got %b want 10", {HREADYOUT, HRESP}); end
    nvec++; if (TIMERINT !== 1'b0) begin nerr++; $display("FAIL rst_int: got %b want 0", TIMERINT); end
    HRESET = 1'b0;
    rd_reg(32'h00);
    nvec++; if (HRDATA !== LOAD_RST) begin nerr++; $display("FAIL rst_load: got %h want %h", HRDATA, LOAD_RST); end
    rd_reg(32'h04);
    nvec++; if (HRDATA !== LOAD_RST) begin nerr++; $display("FAIL rst_value: got %h want %h", HRDATA, LOAD_RST); end
    rd_reg(32'h08);
    nvec++; if (HRDATA !== 32'd0) begin nerr++; $display("FAIL rst_ctrl: got %h want 0", HRDATA); end
    rd_reg(32'h0C);
    nvec++; if (HRDATA !== 32'd0) begin nerr++; $display("FAIL rst_status: got %h want 0", HRDATA); end
    idle();
  endtask

  task automatic test_countdown();
    logic [31:0] want;
    do_reset();
    wr_reg(32'h00, 32'd5);
    wr_reg(32'h08, 32'h5);
    for (int i = 0; i < 7; i++) begin
      rd_reg(32'h04);
      want = (i < 6) ? 32'(5 - i) : 32'd5;
      nvec++; if (HRDATA !== want) begin nerr++; $display("FAIL countdown_value[%0d]: got %0d want %0d", i, HRDATA, want); end
    end
    rd_reg(32'h0C);
    nvec++; if (HRDATA !== 32'd1) begin nerr++; $display("FAIL countdown_flag: got %h want 1", HRDATA); end
    nvec++; if (TIMERINT !== 1'b0) begin nerr++; $display("FAIL countdown_int: got %b want 0", TIMERINT); end
    idle();
  endtask

  task automatic test_periodic();
    int zq[$];
    logic [31:0] want;
    do_reset();
    wr_reg(32'h00, 32'd3);
    wr_reg(32'h08, 32'h7);
    for (int i = 0; i < 12; i++) begin
      rd_reg(32'h04);
      want = 32'(3 - (i % 4));
      nvec++; if (HRDATA !== want) begin nerr++; $display("FAIL periodic_value[%0d]: got %0d want %0d", i, HRDATA, want); end
      nvec++; if (TIMERINT !== (i >= 3)) begin nerr++; $display("FAIL periodic_int[%0d]: got %b want %b", i, TIMERINT, (i >= 3)); end
      if (HRDATA == 32'd0) zq.push_back(i);
    end
    nvec++;
    if (zq.size() < 2) begin nerr++; $display("FAIL periodic_period: got %0d zeros want >=2", zq.size()); end
    else if (zq[1] - zq[0] != 4) begin nerr++; $display("FAIL periodic_period: got %0d want 4", zq[1] - zq[0]); end
    idle();
  endtask

  task automatic test_irq_collision();
    int n = 0;
    do_reset();
    wr_reg(32'h00, 32'd6);
    wr_reg(32'h08, 32'h3);
    idle();
    while (m_value != 32'd2 && n < 20) begin idle(); n++; end
    nvec++; if (n >= 20) begin nerr++; $display("FAIL collide_wait: got timeout want value 2"); end
    wr_reg(32'h0C, 32'd1);
    rd_reg(32'h0C);
    nvec++; if (HRDATA !== 32'd1) begin nerr++; $display("FAIL collide_keep: got %h want 1", HRDATA); end
    nvec++; if (TIMERINT !== 1'b1) begin nerr++; $display("FAIL collide_int: got %b want 1", TIMERINT); end
    wr_reg(32'h0C, 32'd1);
    rd_reg(32'h0C);
    nvec++; if (HRDATA !== 32'd0) begin nerr++; $display("FAIL collide_clear: got %h want 0", HRDATA); end
    nvec++; if (TIMERINT !== 1'b0) begin nerr++; $display("FAIL collide_int_clr: got %b want 0", TIMERINT); end
    idle();
  endtask

  task automatic test_load_reload();
    int n = 0;
    do_reset();
    wr_reg(32'h00, 32'd3);
    wr_reg(32'h08, 32'h5);
    idle();
    while (m_value != 32'd1 && n < 20) begin idle(); n++; end
    nvec++; if (n >= 20) begin nerr++; $display("FAIL reload_wait: got timeout want value 1"); end
    wr_reg(32'h00, 32'h10);
    rd_reg(32'h04);
    nvec++; if (HRDATA !== 32'h10) begin nerr++; $display("FAIL reload_value: got %h want 10", HRDATA); end
    rd_reg(32'h04);
    nvec++; if (HRDATA !== 32'h0F) begin nerr++; $display("FAIL reload_next: got %h want 0f", HRDATA); end
    rd_reg(32'h00);
    nvec++; if (HRDATA !== 32'h10) begin nerr++; $display("FAIL reload_load: got %h want 10", HRDATA); end
    idle();
  endtask

  task automatic test_unmapped();
    do_reset();
    wr_reg(32'h00, 32'h55);
    idle();
    rd_reg(32'h14);
    nvec++; if (HRDATA !== 32'd0) begin nerr++; $display("FAIL unmapped_rd: got %h want 0", HRDATA); end
    nvec++; if ({HREADYOUT, HRESP} !== 2'b10) begin nerr++; $display("FAIL unmapped_resp: got %b want 10", {HREADYOUT, HRESP}); end
    bus_cycle(1'b1, T_NSEQ, 1'b1, 32'h00, 3'b000, 32'hAA);
    nvec++; if ({HREADYOUT, HRESP} !== 2'b10) begin nerr++; $display("FAIL byte_resp: got %b want 10", {HREADYOUT, HRESP}); end
    wr_reg(32'h04, 32'h77);
    rd_reg(32'h00);
    nvec++; if (HRDATA !== 32'h55) begin nerr++; $display("FAIL byte_load: got %h want 55", HRDATA); end
    rd_reg(32'h04);
    nvec++; if (HRDATA !== 32'h55) begin nerr++; $display("FAIL value_ro: got %h want 55", HRDATA); end
    rd_reg(32'h1C);
    nvec++; if (HRDATA !== 32'd0) begin nerr++; $display("FAIL unmapped_1c: got %h want 0", HRDATA); end
    idle();
  endtask

  task automatic test_reset_midwrite();
    do_reset();
    wr_reg(32'h08, 32'h3);
    idle();
    wr_reg(32'h00, 32'h1234);
    HRESET = 1'b1;
    #1;
    nvec++; if (TIMERINT !== 1'b0 || HRDATA !== 32'd0) begin nerr++; $display("FAIL midrst_quiet: got int %b data %h want 0 0", TIMERINT, HRDATA); end
    idle();
    HRESET = 1'b0;
    rd_reg(32'h00);
    nvec++; if (HRDATA !== LOAD_RST) begin nerr++; $display("FAIL midrst_load: got %h want %h", HRDATA, LOAD_RST); end
    rd_reg(32'h08);
    nvec++; if (HRDATA !== 32'd0) begin nerr++; $display("FAIL midrst_ctrl: got %h want 0", HRDATA); end
    idle();
  endtask

  task automatic test_back_to_back();
    bit sel, wr;
    logic [1:0]  trans;
    logic [2:0]  idx, size;
    logic [31:0] r, addr, data, want;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      r     = $urandom;
      sel   = ($urandom_range(0, 9) != 0);
      trans = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      wr    = ($urandom_range(0, 2) == 0);
      idx   = 3'($urandom_range(0, 7));
      addr  = {r[31:5], idx, r[1:0]};
      size  = ($urandom_range(0, 3) != 0) ? SZ_WORD : 3'($urandom_range(0, 1));
      case (idx)
        3'd0:    data = 32'($urandom_range(0, 12));
        3'd2:    data = 32'($urandom_range(0, 7));
        3'd3:    data = 32'($urandom_range(0, 1));
        default: data = $urandom;
      endcase
      bus_cycle(sel, trans, wr, addr, size, data);
      want = last_rd ? mread(last_idx) : 32'd0;
      nvec++; if (HRDATA !== want) begin nerr++; $display("FAIL rand_hrdata[%0d]: got %h want %h", k, HRDATA, want); end
      nvec++; if (TIMERINT !== (m_flag & m_irqen)) begin nerr++; $display("FAIL rand_int[%0d]: got %b want %b", k, TIMERINT, m_flag & m_irqen); end
      nvec++; if ({HREADYOUT, HRESP} !== 2'b10) begin nerr++; $display("FAIL rand_resp[%0d]: got %b want 10", k, {HREADYOUT, HRESP}); end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_countdown();
    test_periodic();
    test_irq_collision();
    test_load_reload();
    test_unmapped();
    test_reset_midwrite();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
